// File: rtl/comparator_seq.sv
// Load/compare sequencer for the 32-lane comparator array: takes A/B operand pairs from a
// valid/ready stream and returns the array result on a valid/ready stream.
// Optional PAIR_CNT result counter when COMPARATOR_SEQ_COUNT_EN is defined.
module comparator_seq #(
  parameter int unsigned RESULT_LAT = 1
) (
  input  logic        CLK,
  input  logic        RSTL,
  input  logic [63:0] S_DATA,
  input  logic        S_MODE,
  input  logic        S_VALID,
  output logic        S_READY,
  output logic [63:0] M_DATA,
  output logic        M_VALID,
  input  logic        M_READY,
  output logic [63:0] CMP_D_IN,
  output logic        CMP_D_EN,
  output logic        CMP_SWITCH,
  output logic        CMP_COMPARE_EN,
  output logic        CMP_COMPARE_MODE,
  input  logic [63:0] CMP_D_OUT,
  output logic        BUSY
`ifdef COMPARATOR_SEQ_COUNT_EN
  ,
  output logic [15:0] PAIR_CNT
`endif
);

  localparam logic [3:0] LatCnt = 4'(RESULT_LAT);

  typedef enum logic [2:0] {
    StIdle,
    StLoadA,
    StLoadB,
    StCmp,
    StWait,
    StOut
  } state_e;

  state_e      state_q, state_d;
  logic        s_ready_q, s_ready_d;
  logic [63:0] d_in_q, d_in_d;
  logic        d_en_q, d_en_d;
  logic        switch_q, switch_d;
  logic        mode_q, mode_d;
  logic        cmp_en_q, cmp_en_d;
  logic        cmp_mode_q, cmp_mode_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] m_data_q, m_data_d;
  logic        m_valid_q, m_valid_d;
  logic        res_hs;

  assign res_hs = (state_q == StOut) && m_valid_q && M_READY;

  always_comb begin
    state_d    = state_q;
    d_in_d     = d_in_q;
    d_en_d     = 1'b0;
    switch_d   = switch_q;
    mode_d     = mode_q;
    cmp_en_d   = 1'b0;
    cmp_mode_d = 1'b0;
    cnt_d      = cnt_q;
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;

    unique case (state_q)
      StIdle: state_d = StLoadA;
      StLoadA: begin
        if (S_VALID && s_ready_q) begin
          d_in_d   = S_DATA;
          d_en_d   = 1'b1;
          switch_d = 1'b0;
          state_d  = StLoadB;
        end
      end
      StLoadB: begin
        if (S_VALID && s_ready_q) begin
          d_in_d   = S_DATA;
          d_en_d   = 1'b1;
          switch_d = 1'b1;
          mode_d   = S_MODE;
          state_d  = StCmp;
        end
      end
      StCmp: begin
        // Compare strobe is registered so it lands one cycle after the B load pulse.
        cmp_en_d   = 1'b1;
        cmp_mode_d = mode_q;
        cnt_d      = LatCnt;
        state_d    = StWait;
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          m_data_d  = CMP_D_OUT;
          m_valid_d = 1'b1;
          state_d   = StOut;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StOut: begin
        if (res_hs) begin
          m_valid_d = 1'b0;
          state_d   = StLoadA;
        end
      end
      default: state_d = StIdle;
    endcase

    s_ready_d = (state_d == StLoadA) || (state_d == StLoadB);
  end

  always_ff @(posedge CLK or negedge RSTL) begin
    if (!RSTL) begin
      state_q    <= StIdle;
      s_ready_q  <= 1'b0;
      d_in_q     <= '0;
      d_en_q     <= 1'b0;
      switch_q   <= 1'b0;
      mode_q     <= 1'b0;
      cmp_en_q   <= 1'b0;
      cmp_mode_q <= 1'b0;
      cnt_q      <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      s_ready_q  <= s_ready_d;
      d_in_q     <= d_in_d;
      d_en_q     <= d_en_d;
      switch_q   <= switch_d;
      mode_q     <= mode_d;
      cmp_en_q   <= cmp_en_d;
      cmp_mode_q <= cmp_mode_d;
      cnt_q      <= cnt_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
    end
  end

  assign S_READY          = s_ready_q;
  assign M_DATA           = m_data_q;
  assign M_VALID          = m_valid_q;
  assign CMP_D_IN         = d_in_q;
  assign CMP_D_EN         = d_en_q;
  assign CMP_SWITCH       = switch_q;
  assign CMP_COMPARE_EN   = cmp_en_q;
  assign CMP_COMPARE_MODE = cmp_mode_q;
  assign BUSY             = (state_q != StIdle) && (state_q != StLoadA);

`ifdef COMPARATOR_SEQ_COUNT_EN
  logic [15:0] pair_cnt_q, pair_cnt_d;

  always_comb begin
    pair_cnt_d = pair_cnt_q;
    if (res_hs && (pair_cnt_q != 16'hFFFF)) begin
      pair_cnt_d = pair_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge CLK or negedge RSTL) begin
    if (!RSTL) begin
      pair_cnt_q <= '0;
    end else begin
      pair_cnt_q <= pair_cnt_d;
    end
  end

  assign PAIR_CNT = pair_cnt_q;
`endif

  a_ready_in_load: assert property (@(posedge CLK) disable iff (!RSTL)
    S_READY |-> ((state_q == StLoadA) || (state_q == StLoadB)));
  a_cmp_single: assert property (@(posedge CLK) disable iff (!RSTL)
    CMP_COMPARE_EN |=> !CMP_COMPARE_EN);
  a_result_hold: assert property (@(posedge CLK) disable iff (!RSTL)
    (M_VALID && !M_READY) |=> (M_VALID && $stable(M_DATA)));

endmodule

// File: doc/comparator_seq.md
# comparator_seq

Sequencer that drives the 32-lane, 2-bit-per-lane comparator array from a valid/ready operand stream and returns its 64-bit result on a valid/ready result stream. It accepts operand pairs: word A loaded with switch low, word B loaded with switch high. It then issues one compare pulse, waits the array's result latency, and holds the captured result until it is consumed. It sits between the operand source (DMA/host buffer) and the comparator array; it is the initiator for the array's load/compare interface.

## Interface
- RESULT_LAT, 1, rising edges from the edge that samples CMP_COMPARE_EN until CMP_D_OUT is valid; legal range 1..15.
- CLK  in  1  system clock, rising edge.
- RSTL  in  1  asynchronous active-low reset.
- S_DATA  in  64  operand word; lane i occupies bits [2i+1:2i], i = 0..31.
- S_MODE  in  1  compare mode; sampled only with the B word.
- S_VALID  in  1  operand valid.
- S_READY  out  1  operand ready.
- M_DATA  out  64  captured compare result, lane-aligned like S_DATA.
- M_VALID  out  1  result valid.
- M_READY  in  1  result consumed.
- CMP_D_IN  out  64  to array D_IN.
- CMP_D_EN  out  1  to array D_EN.
- CMP_SWITCH  out  1  to array SWITCH; 0 = operand A bank, 1 = operand B bank.
- CMP_COMPARE_EN  out  1  to array COMPARE_EN.
- CMP_COMPARE_MODE  out  1  to array COMPARE_MODE.
- CMP_D_OUT  in  64  from array D_OUT.
- BUSY  out  1  high in every state except IDLE and LOAD_A.

## Operation
- States: IDLE, LOAD_A, LOAD_B, CMP, WAIT, OUT.
- IDLE: this is the reset state. It moves to LOAD_A unconditionally on the first edge after RSTL releases.
- LOAD_A: S_READY=1. On S_VALID&S_READY, register CMP_D_IN<=S_DATA, CMP_D_EN<=1 and CMP_SWITCH<=0, then move to LOAD_B.
- LOAD_B: S_READY=1. On handshake, register CMP_D_IN<=S_DATA, CMP_D_EN<=1 and CMP_SWITCH<=1, latch S_MODE, then move to CMP.
- CMP: CMP_COMPARE_EN=1 and CMP_COMPARE_MODE=latched mode for exactly one cycle. Load the wait counter with RESULT_LAT, then move to WAIT.
- WAIT: the counter decrements each edge. When it reaches 0, capture M_DATA<=CMP_D_OUT, set M_VALID<=1 and move to OUT.
- OUT: hold M_DATA and M_VALID. On M_VALID&M_READY, clear M_VALID and move to LOAD_A.
- CMP_D_EN is a one-cycle pulse per accepted word; it is 0 in every other cycle.
- CMP_D_IN holds its last value when CMP_D_EN=0.
- CMP_SWITCH holds its last value.
- S_READY is a registered state decode. It is never high outside LOAD_A or LOAD_B.
- Data passes through unmodified. The block does no per-lane arithmetic and never reorders lanes.

## Timing
- Reset values, held while RSTL=0: all outputs are 0, including CMP_D_IN and M_DATA; state is IDLE.
- Reset mid-operation: the partial pair is discarded, any pending result is dropped, and no compare pulse is emitted.
- CMP_D_EN is high in the cycle after each accepted word.
- Cycle numbering: B is accepted at edge e0. CMP_COMPARE_EN is high between e1 and e2. The array samples it at e2. M_VALID rises at e2+RESULT_LAT, i.e. 2+RESULT_LAT edges after B acceptance (3 with the default).
- Back-to-back A and B words are accepted on consecutive edges with no bubble.
- If M_READY is already high when M_VALID rises, the result is consumed at the next edge. The next A word is accepted at the earliest one edge after that.
- Pair throughput with S_VALID and M_READY held high: one pair per 5+RESULT_LAT cycles.
- M_DATA and M_VALID are stable while M_READY=0. There is no overflow case, because no new operand is accepted while a result is pending.

## Configuration
- COMPARATOR_SEQ_COUNT_EN defined: adds the output PAIR_CNT, 16 bits.
  - Reset value 0.
  - Increments on each result handshake in OUT.
  - Saturates at 16'hFFFF.
- COMPARATOR_SEQ_COUNT_EN not defined: the PAIR_CNT port and counter logic do not exist; all other behaviour is identical.

## Test plan
- Reset, then A=64'h0123_4567_89AB_CDEF, B=64'hFFFF_0000_AAAA_5555, S_MODE=1, M_READY=1 → CMP_D_EN pulses with SWITCH 0 then 1 carrying those words. One CMP_COMPARE_EN pulse with MODE=1. M_VALID rises 3 edges after B acceptance with M_DATA equal to CMP_D_OUT at that edge.
- M_READY held 0 for 10 cycles after M_VALID, while the array model changes CMP_D_OUT → M_DATA is unchanged, S_READY=0 and BUSY=1 throughout. M_VALID falls one edge after M_READY goes high.
- Continuous S_VALID and M_READY, 4 pairs, RESULT_LAT=3 → exactly 4 results in order, 8 cycles per pair, exactly 4 CMP_COMPARE_EN pulses.
- RSTL asserted between the A and B words → all outputs go 0 immediately. After release, the next word is loaded with SWITCH=0 and no compare pulse is issued for the aborted pair.
- S_VALID toggling 1/0 every cycle → only handshaked words reach CMP_D_IN. S_MODE sampled on the A word is ignored.
- With COMPARATOR_SEQ_COUNT_EN defined: 3 consumed results → PAIR_CNT=3. Preload the counter near saturation → it holds at 16'hFFFF.
